voice_allocator: RTL and testbench



---
 rtl/voice_allocator_pkg.sv | 18 +
 rtl/voice_allocator_voice_slot.sv | 48 ++++
 rtl/voice_allocator.sv | 189 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the polyphony voice allocator.
package voice_allocator_pkg;

   localparam int NOTE_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DECIDE,
      ST_RETRIG
   } state_t;

   // LSB of a slot's note field within the packed voice_note bus.
   function automatic int note_lsb(input int slot);
      return slot * NOTE_W;
   endfunction

endpackage

// File: rtl/voice_allocator_voice_slot.sv
// One voice slot: note, gate and saturating age registers driven by strobes.
module voice_allocator_voice_slot
   import voice_allocator_pkg::*;
#(
   parameter int AGE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [NOTE_W-1:0] i_note,
   input  logic              i_clr_gate,
   input  logic              i_age_inc,
   input  logic              i_age_clr,
   output logic [NOTE_W-1:0] o_note,
   output logic              o_gate,
   output logic [AGE_W-1:0]  o_age
);

   logic [NOTE_W-1:0] r_note;
   logic              r_gate;
   logic [AGE_W-1:0]  r_age;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_note <= '0;
         r_gate <= 1'b0;
         r_age  <= '1;
      end else begin
         // A gate clear (panic or release) always beats a load.
         if (i_clr_gate) begin
            r_gate <= 1'b0;
         end else if (i_load) begin
            r_gate <= 1'b1;
            r_note <= i_note;
         end
         if ((i_load && !i_clr_gate) || i_age_clr) begin
            r_age <= '0;
         end else if (i_age_inc && (r_age != '1)) begin
            r_age <= r_age + 1'b1;
         end
      end
   end

   assign o_note = r_note;
   assign o_gate = r_gate;
   assign o_age  = r_age;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: assigns note events to voice slots with retrigger and stealing.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES    = 4,
   parameter int AGE_W         = 4,
   parameter int RETRIG_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ev_valid,
   output logic                         ev_ready,
   input  logic                         ev_on,
   input  logic [NOTE_W-1:0]            ev_note,
   input  logic                         all_off,
   output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_gate,
   output logic                         stolen,
   output logic                         busy
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = 4;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic              r_on;
   logic [NOTE_W-1:0] r_note;
   logic              r_match_found;
   logic [IDX_W-1:0]  r_match_idx;
   logic              r_free_found;
   logic [IDX_W-1:0]  r_free_idx;
   logic [AGE_W-1:0]  r_free_age;
   logic              r_steal_found;
   logic [IDX_W-1:0]  r_steal_idx;
   logic [AGE_W-1:0]  r_steal_age;
   logic [IDX_W-1:0]  r_target;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_stolen;

   logic [NOTE_W-1:0] w_note [NUM_VOICES];
   logic [AGE_W-1:0]  w_age  [NUM_VOICES];
   logic [NUM_VOICES-1:0] w_sel;
   logic              w_accept;
   logic [NOTE_W-1:0] w_cur_note;
   logic              w_cur_gate;
   logic [AGE_W-1:0]  w_cur_age;
   logic              w_do_load;
   logic              w_do_clr;
   logic              w_do_age_clr;
   logic [IDX_W-1:0]  w_tgt;

   assign ev_ready = (r_state == ST_IDLE) && !all_off;
   assign busy     = (r_state != ST_IDLE);
   assign stolen   = r_stolen;
   assign w_accept = ev_valid && ev_ready;

   assign w_cur_note = w_note[r_idx];
   assign w_cur_gate = voice_gate[r_idx];
   assign w_cur_age  = w_age[r_idx];

   // Exactly one slot is addressed per cycle; w_tgt picks it.
   always_comb begin
      w_do_load    = 1'b0;
      w_do_clr     = 1'b0;
      w_do_age_clr = 1'b0;
      w_tgt        = r_target;
      case (r_state)
         ST_DECIDE: begin
            if (!r_on) begin
               if (r_match_found) begin
                  w_do_clr     = 1'b1;
                  w_do_age_clr = 1'b1;
                  w_tgt        = r_match_idx;
               end
            end else if (r_match_found) begin
               w_do_clr = 1'b1;
               w_tgt    = r_match_idx;
            end else if (r_free_found) begin
               w_do_load = 1'b1;
               w_tgt     = r_free_idx;
            end else begin
               w_do_clr = 1'b1;
               w_tgt    = r_steal_idx;
            end
         end
         ST_RETRIG: begin
            if (r_cnt == '0) begin
               w_do_load = 1'b1;
            end
         end
         default: ;
      endcase
   end

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      assign w_sel[gi] = (w_tgt == IDX_W'(gi));
      voice_allocator_voice_slot #(.AGE_W(AGE_W)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .i_load     (!all_off && w_do_load && w_sel[gi]),
         .i_note     (r_note),
         .i_clr_gate (all_off || (w_do_clr && w_sel[gi])),
         .i_age_inc  (w_accept),
         .i_age_clr  (!all_off && w_do_age_clr && w_sel[gi]),
         .o_note     (w_note[gi]),
         .o_gate     (voice_gate[gi]),
         .o_age      (w_age[gi])
      );
      assign voice_note[note_lsb(gi) +: NOTE_W] = w_note[gi];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_on          <= 1'b0;
         r_note        <= '0;
         r_match_found <= 1'b0;
         r_match_idx   <= '0;
         r_free_found  <= 1'b0;
         r_free_idx    <= '0;
         r_free_age    <= '0;
         r_steal_found <= 1'b0;
         r_steal_idx   <= '0;
         r_steal_age   <= '0;
         r_target      <= '0;
         r_cnt         <= '0;
         r_stolen      <= 1'b0;
      end else if (all_off) begin
         r_state  <= ST_IDLE;
         r_stolen <= 1'b0;
      end else begin
         r_stolen <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ev_valid) begin
                  r_on          <= ev_on;
                  r_note        <= ev_note;
                  r_idx         <= '0;
                  r_match_found <= 1'b0;
                  r_free_found  <= 1'b0;
                  r_steal_found <= 1'b0;
                  r_state       <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_cur_gate && (w_cur_note == r_note) && !r_match_found) begin
                  r_match_found <= 1'b1;
                  r_match_idx   <= r_idx;
               end
               // Strict compare keeps the lowest index on equal ages.
               if (!w_cur_gate && (!r_free_found || (w_cur_age > r_free_age))) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_idx;
                  r_free_age   <= w_cur_age;
               end
               if (w_cur_gate && (!r_steal_found || (w_cur_age > r_steal_age))) begin
                  r_steal_found <= 1'b1;
                  r_steal_idx   <= r_idx;
                  r_steal_age   <= w_cur_age;
               end
               r_idx <= r_idx + 1'b1;
               if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
                  r_state <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               r_state <= ST_IDLE;
               if (r_on && (r_match_found || !r_free_found)) begin
                  r_target <= r_match_found ? r_match_idx : r_steal_idx;
                  r_stolen <= !r_match_found;
                  r_cnt    <= CNT_W'(RETRIG_CYCLES - 1);
                  r_state  <= ST_RETRIG;
               end
            end
            ST_RETRIG: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices, 2-cycle retrigger gap).
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_on = 1'b0;
   logic [6:0]  ev_note = '0;
   logic        all_off = 1'b0;
   logic [27:0] voice_note;
   logic [3:0]  voice_gate;
   logic        stolen;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [27:0] exp_notes;

   voice_allocator #(.NUM_VOICES(4), .AGE_W(4), .RETRIG_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_on      (ev_on),
      .ev_note    (ev_note),
      .all_off    (all_off),
      .voice_note (voice_note),
      .voice_gate (voice_gate),
      .stolen     (stolen),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] slot_note(input int i);
      return voice_note[i*7 +: 7];
   endfunction

   task automatic do_reset();
      rst      = 1'b0;
      ev_valid = 1'b0;
      all_off  = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Returns in the first cycle after the handshake edge (cycle T+1).
   task automatic send_event(input logic on, input logic [6:0] note);
      chk("ready_before_send", {31'd0, ev_ready}, 32'd1);
      ev_valid = 1'b1;
      ev_on    = on;
      ev_note  = note;
      tick();
      ev_valid = 1'b0;
      $display("event on=%0d note=%0d gates=%b", on, note, voice_gate);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (ev_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("idle_timeout", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_gate", {28'd0, voice_gate}, 32'd0);
      chk("rst_note", {4'd0, voice_note}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_stolen", {31'd0, stolen}, 32'd0);
      chk("rst_ready", {31'd0, ev_ready}, 32'd1);

      // 1: first note-on lands in slot 0 at handshake+6
      send_event(1'b1, 7'd60);
      for (int k = 1; k <= 5; k++) begin
         chk("t1_ready_low", {31'd0, ev_ready}, 32'd0);
         chk("t1_gate_early", {28'd0, voice_gate}, 32'd0);
         tick();
      end
      chk("t1_gate", {28'd0, voice_gate}, 32'd1);
      chk("t1_note0", {25'd0, slot_note(0)}, 32'd60);
      chk("t1_ready", {31'd0, ev_ready}, 32'd1);

      // 2: fill all four slots, fifth note steals slot 0
      do_reset();
      send_event(1'b1, 7'd60); wait_idle();
      send_event(1'b1, 7'd62); wait_idle();
      send_event(1'b1, 7'd64); wait_idle();
      send_event(1'b1, 7'd65); wait_idle();
      exp_notes = {7'd65, 7'd64, 7'd62, 7'd60};
      chk("t2_full_gate", {28'd0, voice_gate}, 32'hF);
      chk("t2_full_notes", {4'd0, voice_note}, {4'd0, exp_notes});
      send_event(1'b1, 7'd67);
      for (int k = 0; k < 4; k++) tick();
      chk("t2_decide_gate", {28'd0, voice_gate}, 32'hF);
      chk("t2_decide_stolen", {31'd0, stolen}, 32'd0);
      tick();
      chk("t2_stolen_pulse", {31'd0, stolen}, 32'd1);
      chk("t2_gate_low1", {28'd0, voice_gate}, 32'hE);
      tick();
      chk("t2_stolen_end", {31'd0, stolen}, 32'd0);
      chk("t2_gate_low2", {28'd0, voice_gate}, 32'hE);
      chk("t2_busy_retrig", {31'd0, busy}, 32'd1);
      tick();
      exp_notes = {7'd65, 7'd64, 7'd62, 7'd67};
      chk("t2_gate_up", {28'd0, voice_gate}, 32'hF);
      chk("t2_notes", {4'd0, voice_note}, {4'd0, exp_notes});

      // 3: retrigger of a sounding note reuses its slot
      do_reset();
      send_event(1'b1, 7'd60); wait_idle();
      send_event(1'b1, 7'd60);
      for (int k = 0; k < 4; k++) tick();
      chk("t3_decide_gate", {28'd0, voice_gate}, 32'h1);
      tick();
      chk("t3_gate_low1", {28'd0, voice_gate}, 32'h0);
      chk("t3_no_steal", {31'd0, stolen}, 32'd0);
      tick();
      chk("t3_gate_low2", {28'd0, voice_gate}, 32'h0);
      tick();
      chk("t3_gate_up", {28'd0, voice_gate}, 32'h1);
      chk("t3_notes", {4'd0, voice_note}, 32'd60);

      // 4: release, then allocation prefers the oldest free slot
      do_reset();
      send_event(1'b1, 7'd60); wait_idle();
      send_event(1'b1, 7'd62); wait_idle();
      send_event(1'b0, 7'd60); wait_idle();
      chk("t4_release", {28'd0, voice_gate}, 32'h2);
      send_event(1'b1, 7'd70); wait_idle();
      exp_notes = {7'd0, 7'd70, 7'd62, 7'd60};
      chk("t4_alloc_gate", {28'd0, voice_gate}, 32'h6);
      chk("t4_alloc_notes", {4'd0, voice_note}, {4'd0, exp_notes});
      send_event(1'b0, 7'd99); wait_idle();
      chk("t4_ignore_gate", {28'd0, voice_gate}, 32'h6);
      chk("t4_ignore_notes", {4'd0, voice_note}, {4'd0, exp_notes});

      // 5: panic during SCAN drops the event and releases everything
      do_reset();
      send_event(1'b1, 7'd60); wait_idle();
      send_event(1'b1, 7'd62);
      tick();
      all_off = 1'b1;
      #1;
      chk("t5_ready_panic", {31'd0, ev_ready}, 32'd0);
      tick();
      chk("t5_gate_off", {28'd0, voice_gate}, 32'h0);
      chk("t5_idle", {31'd0, busy}, 32'd0);
      all_off = 1'b0;
      #1;
      chk("t5_ready_back", {31'd0, ev_ready}, 32'd1);
      for (int k = 0; k < 6; k++) tick();
      exp_notes = {7'd0, 7'd0, 7'd0, 7'd60};
      chk("t5_dropped", {4'd0, voice_note}, {4'd0, exp_notes});
      chk("t5_gate_still_off", {28'd0, voice_gate}, 32'h0);
      send_event(1'b1, 7'd64); wait_idle();
      exp_notes = {7'd0, 7'd0, 7'd64, 7'd60};
      chk("t5_after_gate", {28'd0, voice_gate}, 32'h2);
      chk("t5_after_notes", {4'd0, voice_note}, {4'd0, exp_notes});

      // 6: reset in the middle of a steal's RETRIG phase
      do_reset();
      send_event(1'b1, 7'd60); wait_idle();
      send_event(1'b1, 7'd62); wait_idle();
      send_event(1'b1, 7'd64); wait_idle();
      send_event(1'b1, 7'd65); wait_idle();
      send_event(1'b1, 7'd67);
      for (int k = 0; k < 5; k++) tick();
      chk("t6_in_retrig", {28'd0, voice_gate}, 32'hE);
      rst = 1'b0;
      tick();
      chk("t6_rst_gate", {28'd0, voice_gate}, 32'h0);
      chk("t6_rst_note", {4'd0, voice_note}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_stolen", {31'd0, stolen}, 32'd0);
      rst = 1'b1;
      send_event(1'b1, 7'd70); wait_idle();
      chk("t6_first_gate", {28'd0, voice_gate}, 32'h1);
      chk("t6_first_note", {4'd0, voice_note}, 32'd70);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
